// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 datapath mux.
// Produces a registered one-hot grant, mux select, busy flag and a hold-limit timeout pulse.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD   = 16,
  parameter int PRIO_RESET = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int             HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [1:0]     PTR_RST   = 2'(PRIO_RESET);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q;
  logic [3:0]    gnt_q;
  logic [1:0]    sel_q;
  logic [1:0]    ptr_q;
  logic [HW-1:0] hold_q;
  logic          timeout_q;

  logic [1:0]    win_d;
  logic [HW-1:0] hold_d;
  logic          rel_early;
  logic          rel_limit;

  // First requester at or after the pointer, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign win_d     = rr_pick(req_i, ptr_q);
  assign hold_d    = hold_q + HW'(1);
  assign rel_early = done_i | ~req_i[sel_q];
  assign rel_limit = (hold_q == HOLD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      ptr_q     <= PTR_RST;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (|req_i) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << win_d;
            sel_q   <= win_d;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          // Any release cause ends the grant once; TIMEOUT flags the hold limit acting alone.
          if (rel_early || rel_limit) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            ptr_q     <= sel_q + 2'd1;
            hold_q    <= '0;
            timeout_q <= rel_limit & ~rel_early;
          end else begin
            hold_q <= hold_d;
          end
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign busy_o    = |gnt_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD   = 16;
  localparam int PRIO_RESET = 0;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_owner;
  int m_held;
  int m_ptr;
  int m_sel;
  bit m_to;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .PRIO_RESET(PRIO_RESET)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .done_i   (done),
    .gnt_o    (gnt),
    .sel_o    (sel),
    .busy_o   (busy),
    .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic [3:0] r, input logic d, input logic rs);
    bit a, b, c;
    if (rs) begin
      m_owner = -1; m_held = 0; m_ptr = PRIO_RESET; m_sel = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = m_owner;
          m_held  = 1;
        end
      end
    end else begin
      a = d;
      b = !r[m_owner];
      c = (m_held == MAX_HOLD);
      if (a || b || c) begin
        m_ptr   = (m_owner + 1) % 4;
        m_to    = c && !a && !b;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    return {g, 2'(m_sel), (m_owner >= 0), m_to};
  endfunction

  // Advance one clock; inputs are held stable across the edge and outputs sampled 1 ns later.
  task automatic tick();
    logic [3:0] r;
    logic d, rs;
    r = req; d = done; rs = rst;
    @(posedge clk);
    #1;
    model_step(r, d, rs);
  endtask

  task automatic do_reset();
    rst = 1; req = 0; done = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 4'b1111; done = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({gnt, sel, busy, timeout} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got gnt=%b sel=%0d busy=%b to=%b, want all zero",
                 i, gnt, sel, busy, timeout);
      end
    end
    rst = 0; req = 0;
    tick();
  endtask

  task automatic test_single_grant();
    do_reset();
    req = 4'b0100;
    tick();
    checks++;
    if ({gnt, sel, busy} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b sel=%0d busy=%b, want 0100/2/1", gnt, sel, busy);
    end
    for (int i = 2; i <= 5; i++) begin
      done = (i == 5);
      tick();
      checks++;
      if ({gnt, sel, busy, timeout} !== exp_vec()) begin
        errors++;
        $display("FAIL single_grant_hold cycle %0d: got %b want %b", i, {gnt, sel, busy, timeout}, exp_vec());
      end
    end
    checks++;
    if ({gnt, busy, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL single_done_release: got gnt=%b busy=%b to=%b, want 0/0/0", gnt, busy, timeout);
    end
    done = 0; req = 0;
    tick();
  endtask

  task automatic test_rr_order();
    int order[$];
    int want[5] = '{0, 1, 2, 3, 0};
    logic prev_busy;
    do_reset();
    req = 4'b1111;
    prev_busy = 0;
    for (int i = 0; i < 14; i++) begin
      done = (m_owner >= 0 && m_held == 2);
      tick();
      checks++;
      if ({gnt, sel, busy, timeout} !== exp_vec()) begin
        errors++;
        $display("FAIL rr_cycle %0d: got %b want %b", i, {gnt, sel, busy, timeout}, exp_vec());
      end
      if (busy && !prev_busy) order.push_back(int'(sel));
      prev_busy = busy;
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d grants, want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != want[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], want[i]);
        end
      end
    end
    req = 0; done = 0;
    tick();
  endtask

  // variant 0: hold limit alone; 1: DONE on the last cycle; 2: REQ drop on the last cycle
  task automatic test_timeout();
    int cnt;
    for (int v = 0; v < 3; v++) begin
      do_reset();
      req = 4'b0001;
      cnt = 0;
      for (int i = 1; i <= 18; i++) begin
        done = (v == 1 && i == 17);
        req  = (v == 2 && i == 17) ? 4'b0000 : 4'b0001;
        tick();
        checks++;
        if ({gnt, sel, busy, timeout} !== exp_vec()) begin
          errors++;
          $display("FAIL timeout_v%0d cycle %0d: got %b want %b", v, i, {gnt, sel, busy, timeout}, exp_vec());
        end
        if (i <= 17 && gnt == 4'b0001) cnt++;
        if (i == 17) begin
          checks++;
          if ({gnt, timeout} !== {4'b0000, (v == 0)}) begin
            errors++;
            $display("FAIL timeout_pulse_v%0d: got gnt=%b to=%b, want 0000/%0d", v, gnt, timeout, (v == 0));
          end
        end
      end
      checks++;
      if (cnt != MAX_HOLD) begin
        errors++;
        $display("FAIL timeout_hold_len_v%0d: got %0d cycles want %0d", v, cnt, MAX_HOLD);
      end
      if (v == 0) begin
        checks++;
        if ({gnt, timeout} !== {4'b0001, 1'b0}) begin
          errors++;
          $display("FAIL timeout_regrant: got gnt=%b to=%b, want 0001/0", gnt, timeout);
        end
      end
    end
    req = 0; done = 0;
    tick();
  endtask

  task automatic test_req_drop();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      req = 4'b0010;
      tick(); tick();
      req = 4'b0000;
      done = (v == 1);
      tick();
      done = 0;
      checks++;
      if ({gnt, busy, timeout} !== 6'b0) begin
        errors++;
        $display("FAIL req_drop_v%0d: got gnt=%b busy=%b to=%b, want 0/0/0", v, gnt, busy, timeout);
      end
      req = 4'b1111;
      tick();
      checks++;
      if ({gnt, sel} !== {4'b0100, 2'd2}) begin
        errors++;
        $display("FAIL req_drop_ptr_v%0d: got gnt=%b sel=%0d, want 0100/2", v, gnt, sel);
      end
      req = 0;
      tick();
    end
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL mid_grant_setup: got gnt=%b want 1000", gnt);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({gnt, sel, busy, timeout} !== 8'h00) begin
      errors++;
      $display("FAIL mid_grant_reset: got gnt=%b sel=%0d busy=%b to=%b, want zeros", gnt, sel, busy, timeout);
    end
    req = 4'b1001;
    tick();
    checks++;
    if ({gnt, sel} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL mid_grant_after_reset: got gnt=%b sel=%0d, want 0001/0", gnt, sel);
    end
    req = 0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < ((i < 400) ? 30 : 5)) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 99) < ((i < 400) ? 20 : 2));
      rst  = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if ({gnt, sel, busy, timeout} !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", i, {gnt, sel, busy, timeout}, exp_vec());
      end
    end
    rst = 0; req = 0; done = 0;
  endtask

  initial begin
    rst = 1; req = 0; done = 0;
    m_owner = -1; m_held = 0; m_ptr = PRIO_RESET; m_sel = 0; m_to = 0;
    test_reset();
    test_single_grant();
    test_rr_order();
    test_timeout();
    test_req_drop();
    test_reset_mid_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
